// File: rtl/mem_refill_pkg.sv
// mem_refill_pkg: shared types and address field positions for the cache refill path
package mem_refill_pkg;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WR, FIN} state_t;
   localparam int ADDR_W     = 12;
   localparam int WORD_W     = 32;
   localparam int LINE_WORDS = 4;
   localparam int LINE_W     = LINE_WORDS * WORD_W;
   localparam int TAG_HI     = 11;
   localparam int TAG_LO     = 7;
   localparam int IDX_HI     = 6;
   localparam int IDX_LO     = 4;
   localparam int OFF_HI     = 3;
   localparam int OFF_LO     = 2;
endpackage

// File: rtl/mem_refill_if.sv
// mem_refill_if: request/response and memory bus of the refill engine
interface mem_refill_if;
   import mem_refill_pkg::*;
   logic              REQ;
   logic              REQ_WEN;
   logic [ADDR_W-1:0] REQ_ADDR;
   logic [3:0]        REQ_BE;
   logic [WORD_W-1:0] REQ_DI;
   logic              BUSY;
   logic              DONE;
   logic [LINE_W-1:0] LINE;
   logic              MEM_CSN;
   logic              MEM_WEN;
   logic [ADDR_W-1:0] MEM_ADDR;
   logic [3:0]        MEM_BE;
   logic [WORD_W-1:0] MEM_DO;
   logic [WORD_W-1:0] MEM_DI;
   modport slave (
      input  REQ, REQ_WEN, REQ_ADDR, REQ_BE, REQ_DI, MEM_DI,
      output BUSY, DONE, LINE, MEM_CSN, MEM_WEN, MEM_ADDR, MEM_BE, MEM_DO
   );
   modport master (
      output REQ, REQ_WEN, REQ_ADDR, REQ_BE, REQ_DI, MEM_DI,
      input  BUSY, DONE, LINE, MEM_CSN, MEM_WEN, MEM_ADDR, MEM_BE, MEM_DO
   );
endinterface

// File: rtl/mem_refill_wait_cnt.sv
// refill_wait_cnt: 4-bit loadable down-counter flagging the final wait cycle
module refill_wait_cnt (
   input  logic       CLK,
   input  logic       RSTN,
   input  logic       load,
   input  logic       en,
   input  logic [3:0] din,
   output logic       last
);
   logic [3:0] cnt;
   always_ff @(posedge CLK or negedge RSTN)
      if (!RSTN) cnt <= '0;
      else if (load) cnt <= din;
      else if (en && cnt != 4'd0) cnt <= cnt - 4'd1;
   assign last = cnt == 4'd1;
endmodule

// File: rtl/mem_refill.sv
// mem_refill: line refill and byte-enabled write-through engine behind the direct-mapped cache
// REFILL_CRITICAL_WORD_FIRST_EN: fetch the requested word first, then wrap
module mem_refill import mem_refill_pkg::*; #(
   parameter int MEM_LAT = 1
) (
   input logic         CLK,
   input logic         RSTN,
   mem_refill_if.slave bus
);
   state_t            state, nstate;
   logic [ADDR_W-1:2] adr;
   logic [1:0]        word, ncap, start;
   logic [3:0]        be;
   logic [WORD_W-1:0] di;
   logic [LINE_W-1:0] line;
   logic              load, last;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
   assign start = bus.REQ_ADDR[OFF_HI:OFF_LO];
`else
   assign start = 2'd0;
`endif

   refill_wait_cnt u_cnt (
      .CLK(CLK), .RSTN(RSTN), .load(load), .en(state == WAIT),
      .din(4'(MEM_LAT)), .last(last)
   );

   always_ff @(posedge CLK or negedge RSTN)
      if (!RSTN) begin
         state <= IDLE;
         adr   <= '0;
         word  <= '0;
         ncap  <= '0;
         be    <= '0;
         di    <= '0;
         line  <= '0;
      end else begin
         state <= nstate;
         if (state == IDLE && bus.REQ) begin
            adr  <= bus.REQ_ADDR[ADDR_W-1:2];
            word <= start;
            ncap <= '0;
            if (!bus.REQ_WEN) begin
               be <= bus.REQ_BE;
               di <= bus.REQ_DI;
            end
         end
         if (state == WAIT && last) begin
            line[{word, 5'b0} +: WORD_W] <= bus.MEM_DI;
            word <= word + 2'd1;
            ncap <= ncap + 2'd1;
         end
      end

   always_comb begin
      load   = state == ISSUE;
      nstate = state == IDLE  ? (bus.REQ ? (bus.REQ_WEN ? ISSUE : WR) : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (last ? (ncap == 2'(LINE_WORDS - 1) ? FIN : ISSUE) : WAIT) :
               state == WR    ? FIN : IDLE;
   end

   // memory side decoded purely from registers so it is stable for the whole cycle
   assign bus.BUSY     = state != IDLE;
   assign bus.DONE     = state == FIN;
   assign bus.LINE     = line;
   assign bus.MEM_CSN  = !(state == ISSUE || state == WR);
   assign bus.MEM_WEN  = state != WR;
   assign bus.MEM_ADDR = state == ISSUE ? {adr[TAG_HI:TAG_LO], adr[IDX_HI:IDX_LO], word, 2'b00} :
                         state == WR    ? {adr, 2'b00} : '0;
   assign bus.MEM_BE   = state == WR ? be : '0;
   assign bus.MEM_DO   = state == WR ? di : '0;
endmodule

// File: doc/mem_refill.md
# mem_refill

Line-refill and write-through engine sitting directly downstream of the 8-line direct-mapped cache, between it and the 12-bit-address, 32-bit-word data memory. On a cache miss it fetches the four 32-bit words of the 16-byte line from memory under a fixed memory latency and returns the assembled 128-bit line. On a store it performs a single byte-enabled word write. The cache holds its freeze output while this block reports BUSY.

## Interface
- MEM_LAT, default 1: wait cycles after each memory access before its read data is sampled; legal range 1..15.
- CLK  input  1  rising-edge clock.
- RSTN  input  1  asynchronous, active-low reset.
- REQ  input  1  single-cycle request strobe; sampled only in IDLE.
- REQ_WEN  input  1  1 = line refill (read), 0 = word write.
- REQ_ADDR  input  12  byte address: tag [11:7], index [6:4], word offset [3:2], byte bits [1:0] ignored.
- REQ_BE  input  4  byte enables for writes.
- REQ_DI  input  32  write data.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle completion pulse.
- LINE  output  128  refilled line; word w occupies [32w+31:32w]; valid while DONE is high and held until the next refill starts.
- MEM_CSN  output  1  active-low memory select.
- MEM_WEN  output  1  active-low memory write enable.
- MEM_ADDR  output  12  memory byte address, word aligned.
- MEM_BE  output  4  memory byte enables.
- MEM_DO  output  32  data to memory.
- MEM_DI  input  32  data from memory.

## Operation
- States: IDLE, ISSUE, WAIT, WR, FIN.
- IDLE with REQ=1:
  - REQ_WEN=1: latch the line address (REQ_ADDR[11:4]) and the start word, clear the word counter, go to ISSUE.
  - REQ_WEN=0: latch address, BE and data, go to WR.
- ISSUE:
  - Drives MEM_CSN=0 and MEM_WEN=1.
  - MEM_ADDR = {line, word, 2'b00}.
  - Loads the wait counter with MEM_LAT, then goes to WAIT.
- WAIT:
  - Memory controls are deasserted (MEM_CSN=1).
  - The counter decrements each cycle.
  - In the cycle where the counter is 1, MEM_DI is written into the LINE slot of the current word.
  - Next state is ISSUE (word+1, 2-bit wrap) if fewer than 4 words are captured, otherwise FIN.
- WR: drives MEM_CSN=0, MEM_WEN=0, MEM_BE and MEM_DO from the latches, then goes to FIN.
- FIN: DONE=1, then IDLE.
- Reset and idle values of all outputs:
  - BUSY=0, DONE=0, LINE=0.
  - MEM_CSN=1, MEM_WEN=1.
  - MEM_ADDR=0, MEM_BE=0, MEM_DO=0.
- REQ while BUSY is ignored and not queued. The cache must re-issue the request after DONE.
- Memory-side outputs are decoded from registered state, so they are glitch-free and valid for the whole cycle.
- Reset assertion at any time forces IDLE asynchronously:
  - MEM_CSN rises immediately.
  - A partial line is discarded (LINE cleared).
  - No DONE is produced for the aborted request.

## Timing
- Cycle 0 is the cycle in which REQ is sampled in IDLE; BUSY rises in cycle 1.
- Refill:
  - Word k is issued in cycle 1 + k·(1+MEM_LAT).
  - Word k is captured at the end of cycle (k+1)·(1+MEM_LAT).
  - DONE is high in cycle 1 + 4·(1+MEM_LAT): cycle 9 for MEM_LAT=1, cycle 17 for MEM_LAT=3.
- Write: the memory access is in cycle 1 and DONE is high in cycle 2.
- BUSY falls in the cycle after DONE. A new REQ is accepted in that cycle at the earliest.
- There are no overlapped or pipelined memory accesses.

## Configuration
- REFILL_CRITICAL_WORD_FIRST_EN defined:
  - The start word is REQ_ADDR[3:2].
  - Words are fetched in wrap order: start, start+1, … mod 4.
- Undefined: the start word is always 0 and the fetch order is 0,1,2,3.
- In both cases LINE slot placement, total latency and DONE timing are identical.

## Structure
- Package mem_refill_pkg holds:
  - the state enum;
  - ADDR_W=12, WORD_W=32, LINE_WORDS=4, LINE_W=128;
  - field positions TAG 11:7, INDEX 6:4, OFFSET 3:2.
- The cache imports the same package.
- One sub-module, refill_wait_cnt: a 4-bit loadable down-counter with load, enable and last (count==1) outputs.

## Test plan
- MEM_LAT=1, refill, REQ_ADDR=12'h0A4, memory returns addr^32'h5A5A0000:
  - MEM_ADDR is 0A0, 0A4, 0A8, 0AC in cycles 1, 3, 5, 7.
  - DONE is high in cycle 9.
  - LINE = {5A5A00AC, 5A5A00A8, 5A5A00A4, 5A5A00A0}.
- Same stimulus with REFILL_CRITICAL_WORD_FIRST_EN:
  - Issue order is 0A4, 0A8, 0AC, 0A0.
  - LINE value and cycle-9 DONE are unchanged.
- Write, REQ_ADDR=12'h013, BE=4'b0011, DI=32'hDEADBEEF:
  - Cycle 1: MEM_CSN=0, MEM_WEN=0, MEM_ADDR=010, MEM_BE=0011, MEM_DO=DEADBEEF.
  - DONE is high in cycle 2.
- MEM_LAT=3 refill: word issues in cycles 1, 5, 9, 13 and DONE in cycle 17; REQ pulsed in cycle 6 is ignored, with no extra memory access.
- RSTN asserted in cycle 4 of a MEM_LAT=1 refill:
  - MEM_CSN=1, BUSY=0 and LINE=0 immediately.
  - No DONE follows.
  - After release, a fresh refill completes normally.
